sync_fifo: RTL and testbench

- Single-clock synchronous FIFO, 8-bit data, 16 entries deep by default.
- Buffers a byte stream between a producer (we/data_in) and a consumer (re/data_out) in the same clock domain.
- Provides full and empty status flags.
- Serves as the DUT for the block-level generator/driver/monitor/scoreboard environment, which runs 32 random transactions.

---
 rtl/sync_fifo_if.sv | 28 ++
 rtl/sync_fifo.sv | 74 +++++++
 tb/tb_sync_fifo.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/sync_fifo_if.sv
// sync_fifo_if: producer/consumer bus of the single-clock byte FIFO.
// Status signals (count, overflow, underflow) exist only when FIFO_STATUS_EN is defined.
interface sync_fifo_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  we;
  logic                  re;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  full;
  logic                  empty;
`ifdef FIFO_STATUS_EN
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (output data_in, we, re,
                  input  data_out, full, empty, count, overflow, underflow);
  modport slave  (input  data_in, we, re,
                  output data_out, full, empty, count, overflow, underflow);
`else
  modport master (output data_in, we, re,
                  input  data_out, full, empty);
  modport slave  (input  data_in, we, re,
                  output data_out, full, empty);
`endif
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO, registered read data, full/empty derived from wrap-bit pointers.
// Define FIFO_STATUS_EN to add occupancy count and sticky overflow/underflow outputs.
module sync_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input logic        clk,
  input logic        reset,
  sync_fifo_if.slave bus
);
  localparam int unsigned PTR_W = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  empty_c;
  logic                  full_c;
  logic                  rd_en;
  logic                  wr_en;

  // Same index with opposite wrap bits means the writer is a full lap ahead.
  assign empty_c = (wr_ptr == rd_ptr);
  assign full_c  = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                   (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);

  // A read while full frees a slot, so the same-cycle write may use it.
  assign rd_en = bus.re && !empty_c;
  assign wr_en = bus.we && (!full_c || rd_en);

  // Storage is intentionally not reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[ADDR_WIDTH-1:0]] <= bus.data_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      data_q <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
        data_q <= mem[rd_ptr[ADDR_WIDTH-1:0]];
      end
    end
  end

  assign bus.data_out = data_q;
  assign bus.full     = full_c;
  assign bus.empty    = empty_c;

`ifdef FIFO_STATUS_EN
  logic overflow_q;
  logic underflow_q;

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (bus.we && full_c && !bus.re) overflow_q  <= 1'b1;
      if (bus.re && empty_c)           underflow_q <= 1'b1;
    end
  end

  assign bus.count     = wr_ptr - rd_ptr;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`endif
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed plus random stimulus against a queue model of the FIFO.
// Status outputs are also checked when FIFO_STATUS_EN is defined.
module tb_sync_fifo;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;

  logic clk;
  logic reset;

  sync_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int unsigned   n_tests;
  int unsigned   n_fail;
  logic [DW-1:0] q[$];
  logic [DW-1:0] exp_dout;
  logic          exp_ovf;
  logic          exp_unf;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".dout"},  32'(bus.data_out), 32'(exp_dout));
    check({tag, ".full"},  32'(bus.full),     32'(q.size() == DEPTH));
    check({tag, ".empty"}, 32'(bus.empty),    32'(q.size() == 0));
`ifdef FIFO_STATUS_EN
    check({tag, ".count"}, 32'(bus.count),     32'(q.size()));
    check({tag, ".ovf"},   32'(bus.overflow),  32'(exp_ovf));
    check({tag, ".unf"},   32'(bus.underflow), 32'(exp_unf));
`endif
  endtask

  // One clock of stimulus; the model applies the FIFO rules to its pre-edge occupancy.
  task automatic cycle(input logic we, input logic re, input logic [DW-1:0] din, input string tag);
    bit rd_ok;
    bit wr_ok;
    @(negedge clk);
    bus.we      = we;
    bus.re      = re;
    bus.data_in = din;
    rd_ok = re && (q.size() != 0);
    wr_ok = we && ((q.size() < DEPTH) || rd_ok);
    if (we && !re && q.size() == DEPTH) exp_ovf = 1'b1;
    if (re && q.size() == 0) exp_unf = 1'b1;
    if (rd_ok) exp_dout = q.pop_front();
    if (wr_ok) q.push_back(din);
    @(posedge clk);
    #1;
    check_state(tag);
    bus.we = 1'b0;
    bus.re = 1'b0;
  endtask

  // Reset asserted between edges must clear outputs without a clock edge.
  task automatic async_reset(input string tag);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    q.delete();
    exp_dout = '0;
    exp_ovf  = 1'b0;
    exp_unf  = 1'b0;
    check_state(tag);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    exp_dout    = '0;
    exp_ovf     = 1'b0;
    exp_unf     = 1'b0;
    reset       = 1'b0;
    bus.we      = 1'b0;
    bus.re      = 1'b0;
    bus.data_in = '0;

    repeat (2) @(posedge clk);
    #1;
    check_state("reset");
    @(negedge clk);
    reset = 1'b1;

    cycle(1'b0, 1'b1, 8'h00, "rd_empty");
    check("rd_empty.const", 32'(bus.data_out), 32'h00);

    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 8'(i), "fill");
    check("fill.full_const", 32'(bus.full), 32'h1);
    cycle(1'b1, 1'b0, 8'hAA, "fill_ovf");

    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 1'b1, 8'h00, "drain");
      check("drain.const", 32'(bus.data_out), 32'(i));
    end
    check("drain.empty_const", 32'(bus.empty), 32'h1);
    cycle(1'b0, 1'b1, 8'h00, "drain_unf");
    check("drain_unf.const", 32'(bus.data_out), 32'h0F);

    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 8'($urandom), "wrap_wr");
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 8'h00, "wrap_rd");
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 8'(8'h50 + i), "wrap_fill");
    check("wrap.full_const", 32'(bus.full), 32'h1);

    cycle(1'b1, 1'b1, 8'hC3, "simul_full");
    check("simul_full.const", 32'(bus.data_out), 32'h50);
    check("simul_full.full_const", 32'(bus.full), 32'h1);
    for (int i = 1; i < 16; i++) begin
      cycle(1'b0, 1'b1, 8'h00, "wrap_drain");
      check("wrap_drain.const", 32'(bus.data_out), 32'(8'h50 + i));
    end
    cycle(1'b0, 1'b1, 8'h00, "c3_last");
    check("c3_last.const", 32'(bus.data_out), 32'hC3);

    cycle(1'b1, 1'b1, 8'h11, "simul_empty");
    check("simul_empty.const", 32'(bus.data_out), 32'hC3);
    check("simul_empty.empty_const", 32'(bus.empty), 32'h0);

    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'($urandom), "pre_rst");
    async_reset("mid_rst");
    check("mid_rst.dout_const", 32'(bus.data_out), 32'h00);
    cycle(1'b0, 1'b0, 8'h00, "post_rst");

    // Alternate write-heavy and read-heavy phases to reach both full and empty.
    for (int i = 0; i < 400; i++) begin
      int unsigned pw;
      pw = (((i / 50) % 2) == 0) ? 75 : 30;
      cycle(logic'($urandom_range(99) < pw), logic'($urandom_range(99) < (100 - pw)),
            8'($urandom), "rand");
    end

    async_reset("end_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
